// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - instruction fetch responder: ROM request issue, in-order tagged return FIFO
module imem_fetch_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    parameter logic [DATA_WIDTH-1:0] NOP = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_imem,
    input  logic                  fetch_req,
    output logic                  fetch_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_q,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  decode_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR      = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE       = PTR_W'(1);
    localparam logic [CNT_W-1:0] FULL_COUNT    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_CREDITS = (CNT_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_pc;

    logic [CNT_W:0]        credits_used;
    logic                  accept;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    // Credits cover both queued entries and the one word still coming back from
    // the ROM, so a granted request always has a FIFO slot when it lands.
    assign credits_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign fetch_ready  = flush | (credits_used < DEPTH_CREDITS);
    assign accept       = fetch_req & fetch_ready;
    assign mem_addr     = address_imem;

    assign instr_valid  = (count != '0);
    assign push         = inflight & ~flush & (count != FULL_COUNT);
    assign pop          = instr_valid & decode_ready & ~flush;

    assign instr_out    = instr_valid ? data_mem[head] : NOP;
    assign instr_pc     = instr_valid ? pc_mem[head]   : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inflight_pc <= address_imem;
            end

            // A flush wipes the queue but still lets the branch-target request
            // through, so it becomes the sole in-flight fetch.
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= next_ptr(tail);
                end
                if (pop) begin
                    head <= next_ptr(head);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[tail] <= mem_q;
            pc_mem[tail]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - scoreboard bench for imem_fetch_responder
module tb_imem_fetch_responder;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 3;
    localparam logic [DW-1:0] NOP = 32'h0000_0000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address_imem = '0;
    logic          fetch_req = 1'b0;
    logic [DW-1:0] mem_q = '0;
    logic          flush = 1'b0;
    logic          decode_ready = 1'b0;
    logic          fetch_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;

    int checks = 0;
    int errors = 0;
    int dut_acc = 0;

    // Reference: ordered list of addresses owed to decode, plus at most one
    // address the ROM is still returning.
    logic [AW-1:0] exp_q[$];
    bit            pend_v = 1'b0;
    logic [AW-1:0] pend_pc = '0;

    imem_fetch_responder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .NOP(NOP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .address_imem(address_imem),
        .fetch_req(fetch_req),
        .fetch_ready(fetch_ready),
        .mem_addr(mem_addr),
        .mem_q(mem_q),
        .flush(flush),
        .instr_out(instr_out),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .decode_ready(decode_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return 32'hA000_0000 + {20'h0, a};
    endfunction

    always @(posedge clock) mem_q <= rom(mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit req, input logic [AW-1:0] a, input bit fl, input bit dr);
        bit exp_ready;
        bit acc;
        @(negedge clock);
        fetch_req    = req;
        address_imem = a;
        flush        = fl;
        decode_ready = dr;
        #1;
        exp_ready = fl || ((exp_q.size() + int'(pend_v)) < DEPTH);
        chk("fetch_ready", fetch_ready, exp_ready);
        chk("mem_addr", mem_addr, a);
        acc = req && exp_ready;
        if (fetch_req && fetch_ready) dut_acc++;
        @(posedge clock);
        if (fl) exp_q.delete();
        else if (pend_v) exp_q.push_back(pend_pc);
        pend_v  = acc;
        pend_pc = a;
    endtask

    task automatic do_reset();
        #1;
        reset     = 1'b1;
        fetch_req = 1'b0;
        flush     = 1'b0;
        #1;
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_out", instr_out, NOP);
        chk("rst_pc", instr_pc, '0);
        chk("rst_ready", fetch_ready, 1'b1);
        exp_q.delete();
        pend_v = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compares the presented head against the scoreboard and retires on consume.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                chk("instr_valid", instr_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    chk("instr_pc", instr_pc, exp_q[0]);
                    chk("instr_out", instr_out, rom(exp_q[0]));
                    if (decode_ready && !flush) void'(exp_q.pop_front());
                end else begin
                    chk("empty_out", instr_out, NOP);
                    chk("empty_pc", instr_pc, '0);
                end
            end
        end
    end

    initial begin
        #1;
        chk("init_valid", instr_valid, 1'b0);
        chk("init_out", instr_out, NOP);
        chk("init_pc", instr_pc, '0);
        chk("init_ready", fetch_ready, 1'b1);
        #1;
        reset = 1'b0;

        // streaming, one per cycle
        for (int i = 0; i < 10; i++) cycle(1'b1, AW'(i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // back-pressure: exactly DEPTH accepts while stalled
        dut_acc = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1, AW'(i), 1'b0, 1'b0);
        chk("stall_accepts", dut_acc, DEPTH);
        for (int i = 3; i < 10; i++) cycle(1'b1, AW'(i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // flush as pc 5 returns, branch target 0x40 in the same cycle
        cycle(1'b1, 12'd3, 1'b0, 1'b0);
        cycle(1'b1, 12'd4, 1'b0, 1'b0);
        cycle(1'b1, 12'd5, 1'b0, 1'b0);
        cycle(1'b1, 12'h040, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // flush while full and stalled, no request
        for (int i = 0; i < 5; i++) cycle(1'b1, AW'(i + 16), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // asynchronous reset with queued and in-flight work
        for (int i = 0; i < 4; i++) cycle(1'b1, AW'(i + 32), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) do_reset();
            cycle(($urandom_range(0, 9) < 7), AW'($urandom), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Instruction-fetch responder between the PC register and the decode stage. Accepts word addresses from the PC stage, drives a synchronous single-cycle-latency instruction ROM, and returns each fetched word tagged with its address in order through a small FIFO. Provides back-pressure (`fetch_ready`) to gate the PC enable and supports pipeline flush on taken branches and jumps.

## Interface
- `ADDR_WIDTH`, 12: instruction word-address width, matching the PC-to-imem address.
- `DATA_WIDTH`, 32: instruction width.
- `DEPTH`, 3: FIFO entries; minimum 2. A value of 3 is needed for one fetch per cycle.
- `NOP`, 32'h00000000: value driven on `instr_out` when the FIFO is empty.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `address_imem`  in  ADDR_WIDTH  fetch address from the PC stage.
- `fetch_req`  in  1  the PC stage requests a fetch this cycle.
- `fetch_ready`  out  1  a request is accepted this cycle if `fetch_req` is also high. The PC enable is `fetch_req & fetch_ready`.
- `mem_addr`  out  ADDR_WIDTH  ROM address; combinationally equal to `address_imem`.
- `mem_q`  in  DATA_WIDTH  ROM data; valid the cycle after the address is presented.
- `flush`  in  1  discard all fetched and in-flight instructions.
- `instr_out`  out  DATA_WIDTH  FIFO head instruction, or `NOP` when empty.
- `instr_pc`  out  ADDR_WIDTH  address of the FIFO head instruction, or 0 when empty.
- `instr_valid`  out  1  the FIFO is non-empty.
- `decode_ready`  in  1  decode consumes the head this cycle if `instr_valid` is high.

## Operation
- **Accept:** `acc = fetch_req & fetch_ready`. On acceptance, set `inflight` to 1 and capture `address_imem` into `inflight_pc`. Otherwise clear `inflight` to 0.
- **Return:**
  - In the cycle after acceptance, `mem_q` is valid while `inflight` is 1.
  - At the end of that cycle, push `{mem_q, inflight_pc}` at the FIFO tail, unless `flush` is high.
- **Pop:** `pop = instr_valid & decode_ready` advances the head pointer.
- **Credit rule:** `fetch_ready = (count + inflight) < DEPTH`.
  - This depends on registered state only, so there is no combinational path from `decode_ready`.
  - The rule guarantees the FIFO never overflows.
- **Simultaneous push and pop:** both occur. `count` is unchanged and both pointers advance.
- **Pointers:** head and tail wrap modulo `DEPTH`. `count` is `$clog2(DEPTH+1)` bits wide. Push is suppressed when full and pop when empty; both states are unreachable if the credit rule holds.
- **Flush has priority over push and pop:**
  - FIFO cleared: `count` = 0, head = tail = 0.
  - The returning `mem_q` of the current cycle is discarded.
  - `fetch_ready` is forced to 1 during a flush cycle.
  - A request in the flush cycle is the branch target. It is accepted and becomes the only in-flight fetch.
- **Order:** instructions leave in the same order they were accepted. There is no reordering and no duplication.

## Timing
- **Reset values:**
  - `instr_valid` = 0, `instr_out` = `NOP`, `instr_pc` = 0, `fetch_ready` = 1.
  - `inflight` = 0, `count` = 0.
- **Reset mid-operation:** asserting `reset` drops all queued and in-flight instructions immediately, without waiting for a clock edge.
- **Latency:** accept at cycle n → `mem_q` sampled at n+1 → `instr_valid` and `instr_out` valid at n+2.
- **Throughput:** with `DEPTH` = 3 and `decode_ready` held high, one instruction per cycle is sustained indefinitely.
- **Stall:** with `decode_ready` low, at most `DEPTH` instructions are accepted. `fetch_ready` falls in the cycle after the last credit is used. The head is held stable with `instr_out` and `instr_pc` unchanged.
- **Outputs:** `instr_out`, `instr_pc` and `instr_valid` are combinational reads of registered FIFO state, with no input-to-output paths. `mem_addr` is the only combinational pass-through.

## Test plan
- **Reset:** assert `reset` asynchronously between edges → outputs show reset values at once (`instr_valid` 0, `instr_out` 0, `fetch_ready` 1), before the next edge.
- **Streaming:** addresses 0,1,2,…,9 requested every cycle, ROM returns `32'hA000_0000 + addr`, `decode_ready` = 1 → `instr_valid` from cycle 2. The sequence is `A0000000`..`A0000009` with `instr_pc` 0..9 and no bubbles.
- **Back-pressure:** `decode_ready` = 0 from cycle 0 with `fetch_req` held high → exactly 3 accepts. `fetch_ready` = 0 from cycle 3. The head stays at `pc` 0 until release; then `pc` 0,1,2 drain in order, followed by further fetches.
- **Flush with in-flight data:** flush in the cycle in-flight `pc` 5 returns, with request `pc` 0x40 in the same cycle → `pc` 5 is never output. FIFO is empty next cycle, and `pc` 0x40 appears 2 cycles after the flush.
- **Flush while full:** flush while full and stalled with no request → `instr_valid` 0 and `fetch_ready` 1 in the next cycle. No stale instruction appears later.
- **Random:** randomized `fetch_req`, `decode_ready` and `flush` over 10k cycles against a reference queue model → order is preserved, there is no overflow, and `count + inflight ≤ DEPTH` always.
